// File: rtl/grid_pkg.sv
// Shared encodings for the grid cursor: direction codes, repeat-timer states
// and a small compile-time helper.
package grid_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/repeat_timer.sv
// Press/hold timer: fires on a new press, again after DELAY cycles of hold,
// then every PERIOD cycles until the press ends.
module repeat_timer
  import grid_pkg::*;
#(
  parameter int DELAY  = 25000000,
  parameter int PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic restart,
  output logic step_fire
);

  localparam int CNT_W = (max_int(DELAY, PERIOD) > 1) ? $clog2(max_int(DELAY, PERIOD)) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_fire = 1'b0;
    limit     = (state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;
    case (state_q)
      ST_IDLE: begin
        if (active) begin
          step_fire = 1'b1;
          cnt_d     = '0;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!active) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (restart) begin
          // A different button replaces the held one: re-arm the long delay.
          step_fire = 1'b1;
          cnt_d     = '0;
          state_d   = ST_DELAY;
        end else if (cnt_q == limit) begin
          step_fire = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/grid_cursor.sv
// Cursor on a bounded grid driven by four direction buttons, with auto-repeat,
// clamp or wrap at the edges, synchronous load and moved/blocked pulses.
module grid_cursor
  import grid_pkg::*;
#(
  parameter int X_W           = 6,
  parameter int Y_W           = 5,
  parameter int X_MAX         = 39,
  parameter int Y_MAX         = 29,
  parameter int X_START       = 1,
  parameter int Y_START       = 1,
  parameter bit WRAP          = 1'b0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btnU,
  input  logic           btnD,
  input  logic           btnL,
  input  logic           btnR,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  output logic [X_W-1:0] xpos,
  output logic [Y_W-1:0] ypos,
  output logic [2:0]     dir,
  output logic           moved,
  output logic           blocked
);

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  dir_t           dir_q, sel;
  logic           moved_q, moved_d;
  logic           blocked_q, blocked_d;
  logic           step_fire;

  always_comb begin
    sel = DIR_NONE;
    if (btnU)      sel = DIR_UP;
    else if (btnD) sel = DIR_DOWN;
    else if (btnL) sel = DIR_LEFT;
    else if (btnR) sel = DIR_RIGHT;
  end

  // Holding the timer inactive during load returns it to idle, so a button
  // still held afterwards is taken as a fresh press.
  repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .active    ((sel != DIR_NONE) && !load),
    .restart   (sel != dir_q),
    .step_fire (step_fire)
  );

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (load) begin
      x_d = (load_x > X_LIM) ? X_LIM : load_x;
      y_d = (load_y > Y_LIM) ? Y_LIM : load_y;
    end else if (step_fire) begin
      case (sel)
        DIR_UP: begin
          if (y_q != '0)   begin y_d = y_q - 1'b1; moved_d = 1'b1; end
          else if (WRAP)   begin y_d = Y_LIM;      moved_d = 1'b1; end
          else             blocked_d = 1'b1;
        end
        DIR_DOWN: begin
          if (y_q < Y_LIM) begin y_d = y_q + 1'b1; moved_d = 1'b1; end
          else if (WRAP)   begin y_d = '0;         moved_d = 1'b1; end
          else             blocked_d = 1'b1;
        end
        DIR_LEFT: begin
          if (x_q != '0)   begin x_d = x_q - 1'b1; moved_d = 1'b1; end
          else if (WRAP)   begin x_d = X_LIM;      moved_d = 1'b1; end
          else             blocked_d = 1'b1;
        end
        DIR_RIGHT: begin
          if (x_q < X_LIM) begin x_d = x_q + 1'b1; moved_d = 1'b1; end
          else if (WRAP)   begin x_d = '0;         moved_d = 1'b1; end
          else             blocked_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= X_W'(X_START);
      y_q       <= Y_W'(Y_START);
      dir_q     <= DIR_NONE;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= sel;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end

  assign xpos    = x_q;
  assign ypos    = y_q;
  assign dir     = dir_q;
  assign moved   = moved_q;
  assign blocked = blocked_q;

endmodule

// File: doc/grid_cursor.md
Name: grid_cursor

Overview:
- Parametrised successor to the single-step button movement block.
- Holds an (x, y) cursor on a bounded grid and moves it from the four direction buttons.
- Adds press-edge stepping, hold-to-auto-repeat, boundary clamp or wrap, synchronous position load, and status pulses.
- Sits between the debounced button synchroniser and the display/game logic that consumes xpos/ypos.

Parameters:
- X_W, 6, width of xpos
- Y_W, 5, width of ypos
- X_MAX, 39, largest legal x (must be < 2**X_W)
- Y_MAX, 29, largest legal y (must be < 2**Y_W)
- X_START, 1, x after reset
- Y_START, 1, y after reset
- WRAP, 0, 0 = clamp at edges, 1 = wrap to the opposite edge
- REPEAT_DELAY, 25000000, clk cycles a button is held before auto-repeat starts (>= 2)
- REPEAT_PERIOD, 5000000, clk cycles between auto-repeat steps (>= 1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btnU  in  1  up button (debounced, synchronous to clk)
- btnD  in  1  down button
- btnL  in  1  left button
- btnR  in  1  right button
- load  in  1  synchronous position load strobe
- load_x  in  X_W  x value for load
- load_y  in  Y_W  y value for load
- xpos  out  X_W  cursor x (registered)
- ypos  out  Y_W  cursor y (registered)
- dir  out  3  active direction code (package encoding)
- moved  out  1  one-cycle pulse: position changed by a step
- blocked  out  1  one-cycle pulse: step suppressed at an edge (clamp mode only)

Behaviour:
- Reset (rst low, asynchronous):
  - xpos=X_START, ypos=Y_START
  - dir=DIR_NONE, moved=0, blocked=0
  - FSM=IDLE, repeat counter=0, previous-direction register=DIR_NONE
- Direction selection, combinational every cycle, fixed priority U > D > L > R:
  - sel = highest-priority pressed button, else DIR_NONE.
  - dir output is the registered sel.
- Step semantics:
  - UP decrements y, DOWN increments y, LEFT decrements x, RIGHT increments x.
  - Only one axis moves per step.
- Boundary, WRAP=0:
  - A step that would leave [0, X_MAX] or [0, Y_MAX] leaves the position unchanged.
  - That cycle asserts blocked=1 and moved=0.
- Boundary, WRAP=1:
  - x 0 LEFT -> X_MAX; x X_MAX RIGHT -> 0; same rule on y.
  - moved=1, blocked never asserts.
- FSM states:
  - IDLE:
    - sel != NONE -> one step on this edge, counter=0, go to DELAY.
  - DELAY:
    - sel == NONE -> IDLE.
    - sel changed from the registered dir -> treat as a new press: immediate step, counter=0, stay in DELAY.
    - counter == REPEAT_DELAY-1 -> step, counter=0, go to REPEAT.
    - Otherwise counter++.
  - REPEAT:
    - Same release and change rules as DELAY.
    - counter == REPEAT_PERIOD-1 -> step, counter=0.
    - Otherwise counter++.
- Latency:
  - Press sampled at edge N -> new xpos/ypos and moved visible after edge N.
  - Holding from edge N gives steps at N, N+REPEAT_DELAY, then every REPEAT_PERIOD.
- Load:
  - load=1 has priority over any step that cycle.
  - xpos=min(load_x, X_MAX), ypos=min(load_y, Y_MAX).
  - moved=0, blocked=0; FSM=IDLE, counter=0.
  - A button still held after load ends counts as a new press on the next cycle.
- moved and blocked are registered, high for exactly one cycle per step attempt, never both high.
- Counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Arithmetic uses X_W/Y_W-width compare against bounds, with no signed intermediate.

Decomposition:
- Package grid_pkg:
  - DIR_NONE=3'd0, DIR_UP=3'd1, DIR_DOWN=3'd2, DIR_LEFT=3'd3, DIR_RIGHT=3'd4.
  - FSM state encoding IDLE/DELAY/REPEAT.
- Sub-module repeat_timer:
  - Holds the counter and DELAY/REPEAT phase.
  - Inputs: active, restart.
  - Output: step_fire.
- grid_cursor keeps the priority selection, boundary arithmetic, load and outputs.

Test Plan:
All scenarios use REPEAT_DELAY=8, REPEAT_PERIOD=4 and other defaults.
1. Release rst, idle 5 cycles -> xpos=1, ypos=1, dir=0, moved=0 throughout.
2. btnR held 20 cycles from x=1 -> steps at cycles 0, 8, 12, 16 -> x=5; moved pulses exactly 4 times; dir=4 while held.
3. From (1,1), btnU held 1 cycle (one step) -> ypos=0, moved=1; then 1-cycle pulse again -> ypos=0, blocked=1, moved=0.
4. WRAP=1, x=0, btnL 1-cycle pulse -> xpos=39, moved=1; at x=39, btnR pulse -> xpos=0.
5. btnU and btnR both held from (5,5) -> only y decrements (priority); drop btnU at cycle 3 -> immediate x step to 6, delay restarts (next step 8 cycles later).
6. Hold btnD, assert load with (50,10) at cycle 5 -> position=(39,10), FSM IDLE; next cycle y steps to 11; then pull rst low mid-repeat -> position (1,1) immediately, with no clock edge required.
